// File: rtl/ps2_key_pacer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_key_pacer                                                            |
// | Queues PS/2 key events and replays them with a fixed hold between them.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ps2_key_pacer #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 20000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [10:0]              ps2_key_in,
  output logic [10:0]              ps2_key_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0]  c_IDLE      = 1'b0;
  localparam logic [0:0]  c_HOLD      = 1'b1;
  localparam logic [AW:0] c_DEPTH     = (AW+1)'(DEPTH);
  localparam logic [19:0] c_HOLD_LOAD = 20'(HOLD_CYCLES - 1);

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_strobe;
  logic [0:0]    r_state;
  logic [19:0]   r_hold;
  logic [10:0]   r_key_out;
  logic          r_overflow;

  logic w_event;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Reset also reloads the strobe copy, so an input toggle during reset is absorbed.
  assign w_event = !reset && (ps2_key_in[10] != r_strobe);
  assign w_pop   = (r_state == c_IDLE) && (r_count != '0);
  assign w_push  = w_event && ((r_count < c_DEPTH) || w_pop);
  assign w_drop  = w_event && !w_push;

  always_ff @(posedge clk) begin
    r_strobe <= ps2_key_in[10];
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ps2_key_in[9:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_hold    <= '0;
      r_key_out <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_pop) begin
            r_key_out <= {~r_key_out[10], r_mem[r_rd_ptr]};
            r_hold    <= c_HOLD_LOAD;
            r_state   <= c_HOLD;
          end
        end
        c_HOLD: begin
          // Counter reaching zero costs one more cycle, giving HOLD_CYCLES+1 spacing.
          if (r_hold == '0) begin
            r_state <= c_IDLE;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign ps2_key_out = r_key_out;
  assign count       = r_count;
  assign busy        = (r_state != c_IDLE) || (r_count != '0);
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_pacer.sv
`default_nettype none
// Directed bench for ps2_key_pacer with DEPTH=4, HOLD_CYCLES=8.
module tb_ps2_key_pacer;

  localparam int DEPTH = 4;
  localparam int HOLD  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] key_in = 11'h400;
  logic [10:0] key_out;
  logic [2:0]  count;
  logic        busy;
  logic        overflow;

  int   n_pass  = 0;
  int   n_total = 0;
  logic tog     = 1'b0;

  ps2_key_pacer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_key_in  (key_in),
    .ps2_key_out (key_out),
    .count       (count),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] d);
    key_in = {~key_in[10], d};
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick;
      n++;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL idle_timeout: busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset;
    tick; tick; tick;
    n_total++;
    if (key_out !== 11'h000) $display("FAIL reset_out: got %h required 000", key_out);
    else n_pass++;
    n_total++;
    if ({count, busy, overflow} !== 5'b0) $display("FAIL reset_state: count=%0d busy=%b ovf=%b required 0/0/0", count, busy, overflow);
    else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    n_total++;
    if (count !== 3'd0 || busy !== 1'b0) $display("FAIL reset_no_spurious: count=%0d busy=%b required 0/0", count, busy);
    else n_pass++;
    tog = 1'b0;
  endtask

  task automatic test_single;
    for (int c = 0; c <= 11; c++) begin
      if (c == 1) begin
        n_total++;
        if (count !== 3'd1) $display("FAIL single_count1: got %0d required 1", count);
        else n_pass++;
      end
      if (c == 2) begin
        tog = ~tog;
        n_total++;
        if (key_out !== 11'h615) $display("FAIL single_out: got %h required 615", key_out);
        else n_pass++;
        n_total++;
        if (count !== 3'd0 || busy !== 1'b1) $display("FAIL single_hold: count=%0d busy=%b required 0/1", count, busy);
        else n_pass++;
      end
      if (c == 11) begin
        n_total++;
        if (busy !== 1'b0 || key_out !== 11'h615) $display("FAIL single_end: busy=%b out=%h required 0/615", busy, key_out);
        else n_pass++;
      end
      if (c == 0) send(10'h215);
      tick;
    end
  endtask

  task automatic test_burst;
    logic [9:0] codes [3];
    codes[0] = 10'h215; codes[1] = 10'h21D; codes[2] = 10'h224;
    for (int c = 0; c <= 22; c++) begin
      if (c == 2 || c == 11 || c == 20) begin
        tog = ~tog;
        n_total++;
        if (key_out !== {tog, codes[(c-2)/9]}) $display("FAIL burst_out_c%0d: got %h required %h", c, key_out, {tog, codes[(c-2)/9]});
        else n_pass++;
      end
      if (c == 10 || c == 19) begin
        n_total++;
        if (key_out !== {tog, codes[(c-10)/9]}) $display("FAIL burst_stable_c%0d: got %h required %h", c, key_out, {tog, codes[(c-10)/9]});
        else n_pass++;
      end
      if (c < 3) send(codes[c]);
      tick;
    end
    n_total++;
    if (overflow !== 1'b0 || count !== 3'd0) $display("FAIL burst_end: ovf=%b count=%0d required 0/0", overflow, count);
    else n_pass++;
  endtask

  task automatic test_extended;
    for (int c = 0; c <= 2; c++) begin
      if (c == 2) begin
        tog = ~tog;
        n_total++;
        if (key_out !== {tog, 10'h171} || key_out[8] !== 1'b1 || key_out[9] !== 1'b0)
          $display("FAIL extended_out: got %h required %h", key_out, {tog, 10'h171});
        else n_pass++;
      end
      if (c == 0) send(10'h171);
      tick;
    end
  endtask

  task automatic test_overflow;
    logic [9:0] code;
    for (int c = 0; c <= 48; c++) begin
      if (c == 5) begin
        n_total++;
        if (count !== 3'd4 || overflow !== 1'b0) $display("FAIL ovf_c5: count=%0d ovf=%b required 4/0", count, overflow);
        else n_pass++;
      end
      if (c == 6) begin
        n_total++;
        if (count !== 3'd4 || overflow !== 1'b1) $display("FAIL ovf_c6: count=%0d ovf=%b required 4/1", count, overflow);
        else n_pass++;
      end
      if (c >= 2 && c <= 38 && (c - 2) % 9 == 0) begin
        tog = ~tog;
        code = 10'h101 + 10'((c - 2) / 9);
        n_total++;
        if (key_out !== {tog, code}) $display("FAIL ovf_out_c%0d: got %h required %h", c, key_out, {tog, code});
        else n_pass++;
      end
      if (c == 48) begin
        n_total++;
        if (key_out !== {tog, 10'h105} || count !== 3'd0 || overflow !== 1'b1)
          $display("FAIL ovf_end: out=%h count=%0d ovf=%b required %h/0/1", key_out, count, overflow, {tog, 10'h105});
        else n_pass++;
      end
      if (c < 6) send(10'h101 + 10'(c));
      tick;
    end
  endtask

  task automatic test_full_pop;
    logic [9:0] code;
    reset = 1'b1; tick; reset = 1'b0; tick;
    tog = 1'b0;
    n_total++;
    if (overflow !== 1'b0 || key_out !== 11'h000) $display("FAIL fullpop_reset: ovf=%b out=%h required 0/000", overflow, key_out);
    else n_pass++;
    for (int c = 0; c <= 48; c++) begin
      if (c == 10) begin
        n_total++;
        if (count !== 3'd4 || key_out !== {tog, 10'h301}) $display("FAIL fullpop_c10: count=%0d out=%h required 4/%h", count, key_out, {tog, 10'h301});
        else n_pass++;
      end
      if (c == 11) begin
        n_total++;
        if (count !== 3'd4 || overflow !== 1'b0) $display("FAIL fullpop_c11: count=%0d ovf=%b required 4/0", count, overflow);
        else n_pass++;
      end
      if (c >= 2 && c <= 47 && (c - 2) % 9 == 0) begin
        tog = ~tog;
        code = 10'h301 + 10'((c - 2) / 9);
        n_total++;
        if (key_out !== {tog, code}) $display("FAIL fullpop_out_c%0d: got %h required %h", c, key_out, {tog, code});
        else n_pass++;
      end
      if (c < 5) send(10'h301 + 10'(c));
      if (c == 10) send(10'h306);
      tick;
    end
  endtask

  task automatic test_reset_mid_hold;
    logic bad;
    bad = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      if (c == 3) begin
        n_total++;
        if (count !== 3'd2 || busy !== 1'b1) $display("FAIL midhold_queued: count=%0d busy=%b required 2/1", count, busy);
        else n_pass++;
      end
      if (c == 5) begin
        reset = 1'b0;
        n_total++;
        if (count !== 3'd0 || overflow !== 1'b0 || key_out !== 11'h000 || busy !== 1'b0)
          $display("FAIL midhold_after: count=%0d ovf=%b out=%h busy=%b required 0/0/000/0", count, overflow, key_out, busy);
        else n_pass++;
      end
      if (c < 3) send(10'h240 + 10'(c));
      if (c == 4) begin
        reset = 1'b1;
        send(10'h0AA);
      end
      tick;
    end
    for (int i = 0; i < 50; i++) begin
      if (key_out !== 11'h000 || count !== 3'd0) bad = 1'b1;
      tick;
    end
    n_total++;
    if (bad !== 1'b0 || key_out !== 11'h000) $display("FAIL midhold_quiet: out=%h toggled=%b required 000/0", key_out, bad);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single;
    wait_idle;
    test_burst;
    wait_idle;
    test_extended;
    wait_idle;
    test_overflow;
    wait_idle;
    test_full_pop;
    wait_idle;
    test_reset_mid_hold;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_key_pacer.md
PS2_KEY_PACER -- requirements
Module: ps2_key_pacer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries, power of two, minimum 2.
REQ-002 SHALL have parameter HOLD_CYCLES, default 20000: clk cycles of hold after each emitted event, minimum 1, maximum 2^20-1.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port ps2_key_in, input, 11: [10] toggle strobe, [9] pressed, [8] extended, [7:0] scan code.
REQ-006 SHALL have port ps2_key_out, output, 11: same format as ps2_key_in; feeds the keyboard matrix block's ps2_key input.
REQ-007 SHALL have port count, output, log2(DEPTH)+1: current FIFO occupancy.
REQ-008 SHALL have port busy, output, 1: high when state is not IDLE or count is non-zero.
REQ-009 SHALL have port overflow, output, 1: sticky flag, set when an event is dropped.

Function
REQ-010 SHALL register ps2_key_in[10] every cycle; an event is a cycle where ps2_key_in[10] differs from the registered copy.
REQ-011 SHALL, on an event, push ps2_key_in[9:0] (10 bits) into the FIFO at the end of that cycle.
REQ-012 SHALL accept a push when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-013 SHALL otherwise drop the event, leave the FIFO unchanged and set overflow to 1 until reset.
REQ-014 SHALL implement the FIFO as a circular buffer: read and write pointers log2(DEPTH) bits, wrapping modulo DEPTH; count tracks occupancy.
REQ-015 SHALL, on simultaneous push and pop, leave count unchanged.
REQ-016 SHALL implement an output FSM with two states: IDLE and HOLD.
REQ-017 In IDLE with count > 0, the FSM SHALL pop the head entry in that cycle and register it.
REQ-018 The same pop SHALL load ps2_key_out[9:0] with the head entry, invert ps2_key_out[10], load the hold counter with HOLD_CYCLES-1 and enter HOLD.
REQ-019 In IDLE with count == 0, the FSM SHALL hold all outputs.
REQ-020 In HOLD, the FSM SHALL decrement the hold counter each cycle and return to IDLE in the cycle after the counter reads 0; no pop occurs in HOLD.
REQ-021 Consecutive ps2_key_out[10] toggles SHALL be spaced exactly HOLD_CYCLES+1 cycles while the FIFO stays non-empty.
REQ-022 Latency SHALL be 2 cycles from an event on an empty, IDLE block to the ps2_key_out toggle: push at end of cycle t, pop in t+1, visible in t+2.
REQ-023 ps2_key_out[9:0] SHALL be stable between toggles.
REQ-024 Events SHALL be emitted in arrival order without modification; the pressed and extended bits pass through unchanged.
REQ-025 The block SHALL NOT coalesce, reorder or synthesize events.
REQ-026 Arithmetic width rule: the hold counter SHALL be 20 bits; count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-027 On reset, ps2_key_out SHALL be 11'h000, count 0, read and write pointers 0, state IDLE, hold counter 0 and overflow 0.
REQ-028 On reset, the registered strobe copy SHALL load ps2_key_in[10], so no spurious event follows reset.
REQ-029 Reset asserted mid-HOLD SHALL discard queued entries; no further ps2_key_out toggles occur until a new input event.
REQ-030 An event in a reset cycle SHALL be ignored.
REQ-031 Any reset-induced change of ps2_key_out[10] carries code 8'h00, which downstream ignores; this is accepted behaviour.

Verification (DEPTH=4, HOLD_CYCLES=8)
REQ-032 Single event: toggle in with [9:0]=10'h215 in cycle t -> ps2_key_out=11'h615 in cycle t+2; count returns to 0; busy low at t+11.
REQ-033 Burst: 3 events in consecutive cycles (codes 15, 1D, 24, pressed) -> three output toggles at t+2, t+11 and t+20 in that order; overflow=0.
REQ-034 Overflow: 6 events in consecutive cycles t..t+5 -> events 0-4 emitted; event 5 dropped; overflow=1 from t+6; count peaks at 4.
REQ-035 Full with simultaneous pop: count=4, state IDLE, event arrives in the same cycle -> push accepted, count stays 4, overflow stays 0.
REQ-036 Reset mid-HOLD with 2 queued -> after reset: count=0, overflow=0, ps2_key_out=11'h000, and no toggles for 50 cycles.
REQ-037 Extended release: in [9:0]=10'h171 -> out [9:0]=10'h171 with bit8=1 and bit9=0 preserved.
